// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared request/response types and FSM states for the data memory controller
//
// mem_in_s  : core -> memory request (write_data, valid, wen, byte_not_word, yumi)
// mem_out_s : memory -> core response (read_data, valid, yumi)
// dmem_state_e : controller states IDLE, BUSY, RESP
package data_mem_ctrl_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Latency counter holds latency_p-1, so 4 bits covers the full 1..15 range.
    localparam int cnt_width_lp = 4;

    // Selects one byte lane of a word and zero-extends it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
        return {24'b0, word[8*lane +: 8]};
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// rtl/data_mem_ram.sv - single-port synchronous word RAM with per-byte write enables
//
// Ports:
//   clk   : clock
//   en    : access enable; a read and any enabled byte writes happen on the same edge
//   we    : per-byte write enable (bit b writes wdata[8*b+:8])
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write), held while en is low
module data_mem_ram #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [3:0]              we,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [0:(1<<addr_width_p)-1];

    // No reset on purpose: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - fixed-latency data memory controller with valid/yumi handshakes
//
// Ports:
//   clk             : clock, rising edge
//   reset           : asynchronous active-low reset
//   to_mem_i        : core request (write_data, valid, wen, byte_not_word, yumi = response ack)
//   data_mem_addr_i : byte address of the request
//   from_mem_o      : response (read_data, valid, yumi = request accept, combinational in IDLE)
//   busy_o          : high whenever the controller is not IDLE
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] data_mem_addr_i,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    localparam logic [cnt_width_lp-1:0] cnt_load_lp = cnt_width_lp'(latency_p - 1);

    dmem_state_e             state_q;
    logic [cnt_width_lp-1:0] cnt_q;
    logic [1:0]              lane_q;
    logic                    wen_q;
    logic                    bnw_q;

    logic        accept;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        unused_addr_hi;

    // Bits above the word index wrap; they are deliberately dropped.
    assign unused_addr_hi = ^data_mem_addr_i[31:addr_width_p+2];

    // Gated by reset so nothing is accepted (or written) while reset is held.
    assign accept = reset && (state_q == IDLE) && to_mem_i.valid;

    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = to_mem_i.write_data;
        if (to_mem_i.wen) begin
            if (to_mem_i.byte_not_word) begin
                ram_we    = 4'b0001 << data_mem_addr_i[1:0];
                ram_wdata = {4{to_mem_i.write_data[7:0]}};
            end else begin
                ram_we = 4'b1111;
            end
        end
    end

    // Store commit and load read both happen on the accepting edge; the RAM
    // output register then holds the loaded word until the next accept.
    data_mem_ram #(.addr_width_p(addr_width_p)) u_ram (
        .clk   (clk),
        .en    (accept),
        .we    (ram_we),
        .addr  (data_mem_addr_i[addr_width_p+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            wen_q   <= 1'b0;
            bnw_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (to_mem_i.valid) begin
                        state_q <= BUSY;
                        cnt_q   <= cnt_load_lp;
                        lane_q  <= data_mem_addr_i[1:0];
                        wen_q   <= to_mem_i.wen;
                        bnw_q   <= to_mem_i.byte_not_word;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means the earliest next accept is the following cycle.
                    if (to_mem_i.yumi) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        from_mem_o      = '0;
        from_mem_o.yumi = accept;
        if (state_q == RESP) begin
            from_mem_o.valid = 1'b1;
            if (!wen_q) begin
                from_mem_o.read_data = bnw_q ? lane_extract(ram_rdata, lane_q) : ram_rdata;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter addr_width_p, default 10, meaning log2 of word count of the data memory.
REQ-002 SHALL have parameter latency_p, default 2, meaning BUSY cycles between accept and response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port to_mem_i  input  mem_in_s  core request (write_data, valid, wen, byte_not_word, yumi).
REQ-006 SHALL have port data_mem_addr_i  input  32  byte address of the request.
REQ-007 SHALL have port from_mem_o  output  mem_out_s  response (read_data, valid, yumi).
REQ-008 SHALL have port busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, BUSY, RESP.
REQ-010 SHALL, in IDLE with to_mem_i.valid=1, drive from_mem_o.yumi=1 combinationally in that cycle and move to BUSY with the counter loaded to latency_p-1.
REQ-011 SHALL drive from_mem_o.yumi=0 in BUSY and RESP; requests there are ignored.
REQ-012 SHALL capture address, write_data, wen and byte_not_word on the accepting edge.
REQ-013 SHALL use word index data_mem_addr_i[addr_width_p+1:2] and byte lane data_mem_addr_i[1:0]; higher address bits are ignored (wrap).
REQ-014 SHALL commit stores on the accepting edge: word store writes all 32 bits, byte store writes only lane [8*lane+:8].
REQ-015 SHALL ignore address bits [1:0] on word accesses (no misalignment fault).
REQ-016 SHALL read loads on the accepting edge: word load returns the word, byte load returns the lane zero-extended to 32 bits.
REQ-017 SHALL return read_data=0 for stores.
REQ-018 SHALL decrement the counter each BUSY cycle and enter RESP on the edge where the counter is 0; from_mem_o.valid is first high latency_p+1 cycles after the accept cycle.
REQ-019 SHALL hold from_mem_o.valid=1 and read_data stable in RESP until a cycle with to_mem_i.yumi=1, then return to IDLE on that edge.
REQ-020 SHALL ignore to_mem_i.yumi outside RESP.
REQ-021 SHALL NOT accept a new request in the same cycle a response is acknowledged; the earliest next accept is the following cycle.
REQ-022 SHALL drive from_mem_o.valid=0 and read_data=0 outside RESP.

Reset
REQ-023 SHALL, on reset low at any time including mid-transaction, asynchronously force state IDLE, counter 0, captured request registers 0, from_mem_o all-zero and busy_o=0.
REQ-024 SHALL NOT clear memory contents on reset; a store already committed stays committed.

Structure
REQ-025 SHALL take mem_in_s and mem_out_s from the shared definitions package and add dmem_state_e (IDLE, BUSY, RESP) there.
REQ-026 SHALL place storage in one sub-module data_mem_ram (synchronous, one port, byte-write enable); control FSM and counter stay in data_mem_ctrl.

Verification
REQ-027 Word store: addr 0x10, data 0xDEADBEEF, wen=1 -> yumi in accept cycle, valid 3 cycles later (latency_p=2), read_data=0; later word load from 0x10 returns 0xDEADBEEF.
REQ-028 Byte store/load: byte store 0xAB to 0x13 over word 0x11223344 at 0x10 -> word load 0x10 returns 0xAB223344; byte load 0x13 returns 0x000000AB.
REQ-029 Backpressure: hold yumi_i=0 for 5 RESP cycles -> valid and read_data stable all 5; yumi_i=1 -> IDLE next cycle; valid_i held high throughout sees yumi_o only after that.
REQ-030 Wrap: word store 0xCAFEF00D to 0x00001000 (addr_width_p=10) -> word load from 0x0 returns 0xCAFEF00D.
REQ-031 Reset mid-op: assert reset low during BUSY of a load -> outputs zero immediately, no valid after release; a store accepted before reset is still readable.
REQ-032 Ignored signals: yumi_i pulses in IDLE/BUSY and valid_i in BUSY -> no state change, no extra accept, response count equals accept count.
